// File: rtl/riscv_wb_pkg.sv
// Shared definitions for the RV12 write-back stage: load funct3 codes and FSM states.
package riscv_wb_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } wb_state_e;

endpackage

// File: rtl/riscv_wb_ldext.sv
// Load data lane select and sign/zero extension (combinational).
module riscv_wb_ldext
  import riscv_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [2:0]      addr,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] value
);

  localparam int OFFW = (XLEN == 64) ? 3 : 2;

  logic [XLEN-1:0] sh_b, sh_h, sh_w;

  // Shift the addressed lane down to bit 0; addr[0] is ignored for halves.
  always_comb begin
    sh_b = rdata >> {addr[OFFW-1:0], 3'b000};
    sh_h = rdata >> {addr[OFFW-1:1], 4'b0000};
    sh_w = (XLEN == 64) ? (rdata >> {addr[2], 5'b00000}) : rdata;
  end

  always_comb begin
    value = rdata;
    case (funct3)
      LB:  value = XLEN'($signed(sh_b[7:0]));
      LH:  value = XLEN'($signed(sh_h[15:0]));
      LW:  value = XLEN'($signed(sh_w[31:0]));
      LBU: value = XLEN'(sh_b[7:0]);
      LHU: value = XLEN'(sh_h[15:0]);
      LWU: value = (XLEN == 64) ? XLEN'(sh_w[31:0]) : rdata;
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/riscv_wb.sv
// RV12 write-back stage: completes ALU results and loads onto the register file write port.
// Optional retire counter enabled by defining RV_WB_INSTRET_EN.
module riscv_wb
  import riscv_wb_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int AR_BITS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  logic [XLEN-1:0]    mem_pc,
  input  logic               mem_bubble,
  input  logic               mem_we,
  input  logic [AR_BITS-1:0] mem_dst,
  input  logic [XLEN-1:0]    mem_r,
  input  logic               mem_is_load,
  input  logic [2:0]         mem_funct3,
  input  logic               dmem_ack,
  input  logic               dmem_err,
  input  logic [XLEN-1:0]    dmem_rdata,
  input  logic               wb_stall,
  output logic [AR_BITS-1:0] rf_dst,
  output logic [XLEN-1:0]    rf_dstv,
  output logic               rf_we,
  output logic [XLEN-1:0]    wb_pc,
  output logic               wb_exception,
  output logic [63:0]        wb_instret
);

  wb_state_e state, state_nxt;

  logic               accept, take_alu, take_ld, ld_done, retire;
  logic [AR_BITS-1:0] ld_dst;
  logic [XLEN-1:0]    ld_pc, ld_val;
  logic [2:0]         ld_funct3, ld_addr;
  logic               ld_we;

  assign mem_ready = (state == IDLE) & ~wb_stall;
  assign accept    = mem_valid & mem_ready;
  assign take_alu  = accept & ~mem_bubble & ~mem_is_load;
  assign take_ld   = accept & ~mem_bubble &  mem_is_load;
  assign ld_done   = (state == WAIT_ACK) & dmem_ack;
  assign retire    = take_alu | (ld_done & ~dmem_err);

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (take_ld)  state_nxt = WAIT_ACK;
      WAIT_ACK: if (dmem_ack) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  riscv_wb_ldext #(.XLEN(XLEN)) u_ldext (
    .funct3 (ld_funct3),
    .addr   (ld_addr),
    .rdata  (dmem_rdata),
    .value  (ld_val)
  );

  // Load context held while the data memory responds.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ld_dst    <= '0;
      ld_pc     <= '0;
      ld_funct3 <= '0;
      ld_addr   <= '0;
      ld_we     <= 1'b0;
    end else if (take_ld) begin
      ld_dst    <= mem_dst;
      ld_pc     <= mem_pc;
      ld_funct3 <= mem_funct3;
      ld_addr   <= mem_r[2:0];
      ld_we     <= mem_we;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rf_we        <= 1'b0;
      rf_dst       <= '0;
      rf_dstv      <= '0;
      wb_pc        <= '0;
      wb_exception <= 1'b0;
    end else begin
      rf_we        <= 1'b0;
      wb_exception <= 1'b0;
      if (take_alu) begin
        rf_we   <= mem_we & (mem_dst != '0);
        rf_dst  <= mem_dst;
        rf_dstv <= mem_r;
        wb_pc   <= mem_pc;
      end else if (ld_done) begin
        rf_dst <= ld_dst;
        wb_pc  <= ld_pc;
        if (dmem_err) begin
          wb_exception <= 1'b1;
        end else begin
          rf_we   <= ld_we & (ld_dst != '0);
          rf_dstv <= ld_val;
        end
      end
    end

`ifdef RV_WB_INSTRET_EN
  always_ff @(posedge clk or posedge rst)
    if (rst)         wb_instret <= '0;
    else if (retire) wb_instret <= wb_instret + 64'd1;
`else
  assign wb_instret = '0;
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_riscv_wb.sv
// Directed self-checking bench for riscv_wb (XLEN=32).
module tb_riscv_wb;
  import riscv_wb_pkg::*;

  localparam int XLEN = 32;
  localparam int AR_BITS = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               mem_valid = 0, mem_bubble = 0, mem_we = 0, mem_is_load = 0;
  logic [XLEN-1:0]    mem_pc = '0, mem_r = '0, dmem_rdata = '0;
  logic [AR_BITS-1:0] mem_dst = '0;
  logic [2:0]         mem_funct3 = '0;
  logic               dmem_ack = 0, dmem_err = 0, wb_stall = 0;
  logic               mem_ready, rf_we, wb_exception;
  logic [AR_BITS-1:0] rf_dst;
  logic [XLEN-1:0]    rf_dstv, wb_pc;
  logic [63:0]        wb_instret;

  int n_checks = 0;
  int n_fails  = 0;
  int retired  = 0;

  always #5 clk = ~clk;

  riscv_wb #(.XLEN(XLEN), .AR_BITS(AR_BITS)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_pc(mem_pc),
    .mem_bubble(mem_bubble), .mem_we(mem_we), .mem_dst(mem_dst), .mem_r(mem_r),
    .mem_is_load(mem_is_load), .mem_funct3(mem_funct3),
    .dmem_ack(dmem_ack), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
    .wb_stall(wb_stall),
    .rf_dst(rf_dst), .rf_dstv(rf_dstv), .rf_we(rf_we), .wb_pc(wb_pc),
    .wb_exception(wb_exception), .wb_instret(wb_instret)
  );

  function automatic logic [63:0] exp_ir(input int n);
`ifdef RV_WB_INSTRET_EN
    return 64'(n);
`else
    return 64'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({rf_we, wb_exception} !== 2'b00) begin n_fails++; $display("FAIL reset_we_exc got %b want 00", {rf_we, wb_exception}); end
    n_checks++;
    if (rf_dst !== '0 || rf_dstv !== '0 || wb_pc !== '0) begin n_fails++; $display("FAIL reset_regs got dst=%0d v=%h pc=%h want 0", rf_dst, rf_dstv, wb_pc); end
    n_checks++;
    if (wb_instret !== 64'd0) begin n_fails++; $display("FAIL reset_instret got %0d want 0", wb_instret); end
    n_checks++;
    if (mem_ready !== 1'b1) begin n_fails++; $display("FAIL reset_ready got %b want 1", mem_ready); end
    wb_stall = 1'b1; #1;
    n_checks++;
    if (mem_ready !== 1'b0) begin n_fails++; $display("FAIL stall_ready got %b want 0", mem_ready); end
    wb_stall = 1'b0;
    tick();
  endtask

  task automatic test_nonload();
    mem_valid = 1; mem_we = 1; mem_dst = 5; mem_r = 32'h1234_5678; mem_pc = 32'h100;
    tick();
    mem_valid = 0;
    retired++;
    n_checks++;
    if (rf_we !== 1'b1 || rf_dst !== 5'd5 || rf_dstv !== 32'h1234_5678 || wb_pc !== 32'h100) begin
      n_fails++; $display("FAIL nonload_write got we=%b dst=%0d v=%h pc=%h want 1/5/12345678/100", rf_we, rf_dst, rf_dstv, wb_pc);
    end
    n_checks++;
    if (wb_instret !== exp_ir(retired)) begin n_fails++; $display("FAIL nonload_instret got %0d want %0d", wb_instret, exp_ir(retired)); end
    tick();
    n_checks++;
    if (rf_we !== 1'b0) begin n_fails++; $display("FAIL nonload_pulse got %b want 0", rf_we); end
    // Stalled presentation must not be accepted.
    wb_stall = 1; mem_valid = 1; mem_dst = 9;
    tick();
    n_checks++;
    if (rf_we !== 1'b0) begin n_fails++; $display("FAIL stall_noaccept got we=%b want 0", rf_we); end
    wb_stall = 0; mem_valid = 0;
  endtask

  // Accept a load, hold ack for 'dly' cycles after acceptance, then present the response.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd,
                         input logic [4:0] dst, input logic err, input int dly, input logic [31:0] pc);
    mem_valid = 1; mem_is_load = 1; mem_we = 1; mem_funct3 = f3; mem_r = addr; mem_dst = dst; mem_pc = pc;
    dmem_ack = 1; dmem_err = 0; dmem_rdata = 32'h5A5A_5A5A;  // stale ack in acceptance cycle
    tick();
    mem_valid = 0; mem_is_load = 0; dmem_ack = 0;
    for (int i = 1; i < dly; i++) begin
      n_checks++;
      if (mem_ready !== 1'b0 || rf_we !== 1'b0) begin n_fails++; $display("FAIL load_wait got ready=%b we=%b want 0/0", mem_ready, rf_we); end
      tick();
    end
    dmem_ack = 1; dmem_err = err; dmem_rdata = rd; #1;
    n_checks++;
    if (mem_ready !== 1'b0) begin n_fails++; $display("FAIL load_ackcycle_ready got %b want 0", mem_ready); end
    tick();
    dmem_ack = 0; dmem_err = 0;
  endtask

  task automatic check_load(input string nm, input logic [31:0] want);
    retired++;
    n_checks++;
    if (rf_we !== 1'b1 || wb_exception !== 1'b0 || rf_dstv !== want || mem_ready !== 1'b1) begin
      n_fails++; $display("FAIL %s got we=%b exc=%b v=%h rdy=%b want 1/0/%h/1", nm, rf_we, wb_exception, rf_dstv, mem_ready, want);
    end
    n_checks++;
    if (wb_instret !== exp_ir(retired)) begin n_fails++; $display("FAIL %s_instret got %0d want %0d", nm, wb_instret, exp_ir(retired)); end
  endtask

  task automatic test_loads();
    do_load(LB, 32'h1003, 32'h8000_0000, 5'd7, 1'b0, 2, 32'h200);
    check_load("lb", 32'hFFFF_FF80);
    n_checks++;
    if (rf_dst !== 5'd7 || wb_pc !== 32'h200) begin n_fails++; $display("FAIL lb_dst_pc got %0d/%h want 7/200", rf_dst, wb_pc); end
    do_load(LHU, 32'h2002, 32'hBEEF_0000, 5'd8, 1'b0, 1, 32'h204);
    check_load("lhu", 32'h0000_BEEF);
    do_load(LH, 32'h2002, 32'hBEEF_0000, 5'd8, 1'b0, 1, 32'h208);
    check_load("lh", 32'hFFFF_BEEF);
    do_load(LBU, 32'h2001, 32'h0000_A500, 5'd9, 1'b0, 3, 32'h20C);
    check_load("lbu", 32'h0000_00A5);
    do_load(LW, 32'h2000, 32'hDEAD_BEEF, 5'd10, 1'b0, 1, 32'h210);
    check_load("lw", 32'hDEAD_BEEF);
    do_load(LB, 32'h2000, 32'h0000_007F, 5'd11, 1'b0, 1, 32'h214);
    check_load("lb_pos", 32'h0000_007F);
  endtask

  task automatic test_load_fault();
    do_load(LW, 32'h3000, 32'h1111_1111, 5'd12, 1'b1, 2, 32'h220);
    n_checks++;
    if (wb_exception !== 1'b1 || rf_we !== 1'b0 || wb_pc !== 32'h220) begin
      n_fails++; $display("FAIL fault got exc=%b we=%b pc=%h want 1/0/220", wb_exception, rf_we, wb_pc);
    end
    n_checks++;
    if (wb_instret !== exp_ir(retired)) begin n_fails++; $display("FAIL fault_instret got %0d want %0d", wb_instret, exp_ir(retired)); end
    tick();
    n_checks++;
    if (wb_exception !== 1'b0) begin n_fails++; $display("FAIL fault_pulse got %b want 0", wb_exception); end
  endtask

  task automatic test_back_to_back();
    mem_valid = 1; mem_we = 1; mem_dst = 3; mem_r = 32'h0000_AAAA; mem_pc = 32'h300;
    tick();
    retired++;
    n_checks++;
    if (rf_we !== 1'b1 || rf_dst !== 5'd3 || rf_dstv !== 32'h0000_AAAA) begin
      n_fails++; $display("FAIL b2b_first got we=%b dst=%0d v=%h want 1/3/0000aaaa", rf_we, rf_dst, rf_dstv);
    end
    mem_dst = 0; mem_r = 32'h0000_BBBB; mem_pc = 32'h304;
    tick();
    retired++;
    n_checks++;
    if (rf_we !== 1'b0 || wb_pc !== 32'h304 || wb_instret !== exp_ir(retired)) begin
      n_fails++; $display("FAIL b2b_x0 got we=%b pc=%h ir=%0d want 0/304/%0d", rf_we, wb_pc, wb_instret, exp_ir(retired));
    end
    mem_bubble = 1; mem_dst = 4; mem_pc = 32'h308;
    tick();
    mem_valid = 0; mem_bubble = 0;
    n_checks++;
    if (rf_we !== 1'b0 || wb_exception !== 1'b0 || wb_instret !== exp_ir(retired)) begin
      n_fails++; $display("FAIL b2b_bubble got we=%b exc=%b ir=%0d want 0/0/%0d", rf_we, wb_exception, wb_instret, exp_ir(retired));
    end
  endtask

  task automatic test_reset_in_wait();
    mem_valid = 1; mem_is_load = 1; mem_we = 1; mem_funct3 = LW; mem_r = 32'h4000; mem_dst = 6; mem_pc = 32'h400;
    tick();
    mem_valid = 0; mem_is_load = 0;
    rst = 1;
    tick();
    rst = 0;
    retired = 0;
    dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_ack = 0;
    n_checks++;
    if (rf_we !== 1'b0 || wb_exception !== 1'b0 || rf_dst !== '0 || rf_dstv !== '0 || wb_pc !== '0 || wb_instret !== 64'd0) begin
      n_fails++; $display("FAIL late_ack got we=%b exc=%b dst=%0d v=%h pc=%h ir=%0d want all 0", rf_we, wb_exception, rf_dst, rf_dstv, wb_pc, wb_instret);
    end
    n_checks++;
    if (mem_ready !== 1'b1) begin n_fails++; $display("FAIL late_ack_ready got %b want 1", mem_ready); end
  endtask

  initial begin
    test_reset();
    test_nonload();
    test_loads();
    test_load_fault();
    test_back_to_back();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
